// File: rtl/m_lsu.sv
// Memory-stage load/store initiator: word-aligned bus requests, pipeline stall, load extension.
// Define LSU_TRACE_EN to print a trace line on every store grant.
module m_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        adel,
  output logic        ades,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [2:0] DmB  = 3'd1;
  localparam logic [2:0] DmBu = 3'd2;
  localparam logic [2:0] DmH  = 3'd3;
  localparam logic [2:0] DmHu = 3'd4;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  op_q;
  logic        we_q;
  logic [31:0] pc_q;
  logic [3:0]  be_q;
  logic [31:0] bwdata_q;
  logic [31:0] rdata_q;

  logic        in_byte, in_half, misaligned, accept, capture;
  logic [3:0]  be_in;
  logic [31:0] bwdata_in;
  logic [31:0] lane_word;
  logic [31:0] load_ext;

  // Decode of the incoming (not yet latched) request.
  always_comb begin
    in_byte    = (op == DmB) || (op == DmBu);
    in_half    = (op == DmH) || (op == DmHu);
    misaligned = in_half ? addr[0] : (in_byte ? 1'b0 : (addr[1:0] != 2'b00));
    accept     = reset && req_valid && !misaligned && (state_q == StIdle);
    adel       = reset && req_valid && misaligned && !we;
    ades       = reset && req_valid && misaligned && we;
    if (in_byte) begin
      be_in     = 4'b0001 << addr[1:0];
      bwdata_in = {4{wdata[7:0]}};
    end else if (in_half) begin
      be_in     = 4'b0011 << {addr[1], 1'b0};
      bwdata_in = {2{wdata[15:0]}};
    end else begin
      be_in     = 4'b1111;
      bwdata_in = wdata;
    end
  end

  // Halfword accesses are aligned, so the byte-offset shift also selects the right half.
  always_comb begin
    lane_word = bus_rdata >> {addr_q[1:0], 3'b000};
    case (op_q)
      DmB:     load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
      DmBu:    load_ext = {24'h0, lane_word[7:0]};
      DmH:     load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
      DmHu:    load_ext = {16'h0, lane_word[15:0]};
      default: load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      StIdle: if (accept) state_d = StReq;
      StReq: begin
        if (bus_gnt) begin
          if (we_q) begin
            state_d = StDone;
          end else if (bus_rvalid) begin
            state_d = StDone;
            capture = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (bus_rvalid) begin
          state_d = StDone;
          capture = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      addr_q   <= 32'h0;
      op_q     <= 3'd0;
      we_q     <= 1'b0;
      pc_q     <= 32'h0;
      be_q     <= 4'h0;
      bwdata_q <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= addr;
        op_q     <= op;
        we_q     <= we;
        pc_q     <= pc;
        be_q     <= be_in;
        bwdata_q <= bwdata_in;
      end
      if (capture) rdata_q <= load_ext;
    end
  end

  always_comb begin
    stall     = accept || (state_q == StReq) || (state_q == StWait);
    done      = (state_q == StDone);
    bus_req   = (state_q == StReq);
    bus_we    = bus_req && we_q;
    bus_addr  = {addr_q[31:2], 2'b00};
    bus_be    = be_q;
    bus_wdata = bwdata_q;
    rdata     = rdata_q;
  end

`ifdef LSU_TRACE_EN
  logic [31:0] trace_data;
  assign trace_data = bus_wdata & {{8{bus_be[3]}}, {8{bus_be[2]}}, {8{bus_be[1]}}, {8{bus_be[0]}}};

  always @(posedge clk) begin
    if (reset && bus_req && bus_gnt && we_q) begin
      $display("%d@%h: *%h <= %h", $time, pc_q, addr_q, trace_data);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc_q;
`endif

endmodule

// File: doc/m_lsu.md
# m_lsu

Memory-stage load/store initiator. Takes one load or store per instruction from the M stage, converts it to a word-aligned bus request with byte enables, stalls the pipeline until the memory side answers, then returns sign- or zero-extended load data. It is the requesting end of the data-memory bus. It sits between the M-stage pipeline register and a bus-attached data memory with variable latency.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: the M stage holds a memory instruction. It stays stable while `stall`=1.
- `we` in 1: 1 = store, 0 = load.
- `op` in 3: access size. `DM_w`=0, `DM_b`=1, `DM_bu`=2, `DM_h`=3, `DM_hu`=4. Codes 1/2 and 3/4 are the same width when used for a store.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned.
- `pc` in 32: instruction PC, used for trace only.
- `stall` out 1: freeze the F/D/E/M stages.
- `done` out 1: one-cycle pulse when the access completes.
- `rdata` out 32: extended load result. Valid while `done`=1.
- `adel` out 1: misaligned load (combinational).
- `ades` out 1: misaligned store (combinational).
- `bus_req` out 1: request valid.
- `bus_we` out 1: write request.
- `bus_addr` out 32: `{addr[31:2],2'b00}`.
- `bus_be` out 4: byte-lane enables.
- `bus_wdata` out 32: lane-positioned store data.
- `bus_gnt` in 1: request accepted this cycle.
- `bus_rvalid` in 1: read data valid.
- `bus_rdata` in 32: read word.

## Operation
- Misalignment: `DM_w` with `addr[1:0]`≠0, or `DM_h`/`DM_hu` with `addr[0]`=1.
  - With `req_valid`=1 this raises `adel` (load) or `ades` (store).
  - No bus access, no stall, no `done`.
- Byte enables:
  - word: 4'b1111.
  - half: 4'b0011 << (2·`addr[1]`).
  - byte: 4'b0001 << `addr[1:0]`.
- Store data: `wdata[7:0]` is replicated to all four lanes for byte stores, and `wdata[15:0]` to both halves for half stores. Only the lanes selected by `bus_be` are meaningful.
- Load extraction: select the lane of `bus_rdata` using `addr[1:0]`.
  - `DM_b` and `DM_h` sign-extend from the lane MSB.
  - `DM_bu` and `DM_hu` zero-extend.
  - `DM_w` passes the word through.
- Request fields (`addr`, `op`, `we`, `wdata`, `pc`) are latched when the request is accepted out of IDLE. All bus outputs are driven from the latched copies.
- FSM states:
  - IDLE: on aligned `req_valid` → REQ.
  - REQ: `bus_req`=1. On `bus_gnt`:
    - store → DONE.
    - load with `bus_rvalid` in the same cycle → DONE, data captured.
    - load otherwise → WAIT.
  - WAIT: on `bus_rvalid` → DONE, data captured into `rdata`.
  - DONE: `done`=1, then → IDLE unconditionally.
- `stall` = (state==IDLE && aligned `req_valid`) || state==REQ || state==WAIT. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle. `req_valid` seen in DONE belongs to the finished instruction and is ignored.
- `bus_rvalid` outside WAIT, and outside REQ with gnt, is ignored.

## Timing
- Reset values (held while `reset`=0, applied asynchronously):
  - state IDLE.
  - `stall`, `done`, `bus_req`, `bus_we` = 0.
  - `bus_be` = 0.
  - `bus_addr`, `bus_wdata`, `rdata` = 0.
- `adel`/`ades` are combinational from the inputs and are 0 while `reset` is low.
- Reset asserted mid-access drops `bus_req` immediately. A later `rvalid` for that access is ignored.
- `bus_req` and all bus fields stay stable from entering REQ until `bus_gnt`.
- Latency from `req_valid` to `done`:
  - store: 3 cycles with immediate gnt.
  - load: 3 cycles with same-cycle gnt+rvalid, otherwise 3 + wait cycles.
- `rdata` holds its last value after DONE until the next capture.

## Configuration
- `LSU_TRACE_EN` defined: on each store grant, print `$display("%d@%h: *%h <= %h", $time, pc, addr, data)`.
  - `addr` is the latched byte address.
  - `data` is `bus_wdata` with non-enabled lanes forced to 0.
- Undefined: no display statements are compiled. Logic is otherwise identical.

## Test plan
- Word load at 0x0000_0010, gnt in REQ cycle, rvalid 2 cycles later with 0x8765_4321:
  - `stall` high for 4 cycles.
  - `done` pulses with `rdata`=0x8765_4321.
  - `bus_be`=4'b1111.
- `DM_b` load, `addr`=0x13, rdata 0x80FF_1234 → `bus_be`=4'b1000, `rdata`=0xFFFF_FF80. The same access with `DM_bu` → 0x0000_0080.
- `DM_h` store, `addr`=0x22, `wdata`=0x0000_ABCD, gnt delayed 3 cycles:
  - `bus_be`=4'b1100, `bus_wdata`=0xABCD_ABCD.
  - Request fields stable all 3 cycles; `done` one cycle after gnt.
  - With `LSU_TRACE_EN`, prints `*00000022 <= abcd0000`.
- `DM_w` load at 0x6 → `adel`=1, `stall`=0, `bus_req` never asserted. `DM_h` store at 0x5 → `ades`=1.
- Load in WAIT, `reset` pulsed low → all outputs 0 immediately. A subsequent `bus_rvalid` produces no `done`.
- Back-to-back stores with immediate gnt → IDLE→REQ→DONE→IDLE per instruction. No double issue from `req_valid` held in DONE.
